// File: rtl/uinv_arb_pkg.sv
// Shared types and helpers for the inverse-unit arbiter: tag format and
// the round-robin pick used by rr_arbiter.
package uinv_arb_pkg;

  localparam int OUTST_W = 4;
  localparam int MAX_REQ = 16;
  localparam int ID_W    = 4;

  typedef struct packed {
    logic            valid;
    logic [ID_W-1:0] id;
    logic            dz;
  } tag_t;

  // One-hot pick of the first set bit of req at or after ptr, wrapping at n.
  function automatic logic [MAX_REQ-1:0] rr_pick(input logic [MAX_REQ-1:0] req,
                                                 input logic [ID_W-1:0]    ptr,
                                                 input int unsigned        n);
    logic [MAX_REQ-1:0] pick;
    logic               found;
    logic [ID_W-1:0]    idx;
    pick  = '0;
    found = 1'b0;
    for (int unsigned k = 0; k < MAX_REQ; k++) begin
      idx = ID_W'((32'(ptr) + k) % n);
      if (k < n && !found && req[idx]) begin
        pick[idx] = 1'b1;
        found     = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/uinv_arb_rr_arbiter.sv
// Combinational round-robin arbiter: one-hot grant plus its index.
module rr_arbiter
  import uinv_arb_pkg::*;
#(
  parameter int  N     = 4,
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] grant_idx
);

  logic [MAX_REQ-1:0] req_ext;
  logic [MAX_REQ-1:0] pick;

  always_comb begin
    req_ext        = '0;
    req_ext[N-1:0] = req;
    pick           = rr_pick(req_ext, ID_W'(ptr), N);
    grant          = pick[N-1:0];
    grant_idx      = '0;
    // rr_pick never sets bits at or above N, so scanning the full width is safe
    for (int i = 0; i < MAX_REQ; i++) begin
      if (pick[i]) grant_idx = IDX_W'(i);
    end
  end

endmodule

// File: rtl/uinv_arb.sv
// Round-robin front end for a shared pipelined 1/a unit: issues one operand
// per clock, tracks owners through a tag pipe and returns results in order.
module uinv_arb
  import uinv_arb_pkg::*;
#(
  parameter int N_REQ     = 4,
  parameter int WIDTH     = 32,
  parameter int SCALE     = 16,
  parameter int LATENCY   = 34,
  parameter int MAX_OUTST = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [N_REQ-1:0]         req_valid,
  output logic [N_REQ-1:0]         req_ready,
  input  logic [N_REQ*WIDTH-1:0]   req_a,
  output logic [WIDTH-1:0]         inv_a,
  input  logic [WIDTH-1:0]         inv_f,
  output logic [N_REQ-1:0]         rsp_valid,
  output logic [WIDTH-1:0]         rsp_f,
  output logic                     rsp_dz,
  output logic [N_REQ*OUTST_W-1:0] outst
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [OUTST_W-1:0] MAX_O = OUTST_W'(MAX_OUTST);

  if (SCALE >= WIDTH) begin : g_scale_chk
    $error("uinv_arb: SCALE must be smaller than WIDTH");
  end

  logic [N_REQ-1:0]   eligible, grant;
  logic [IDX_W-1:0]   grant_idx, ptr_q, ptr_d;
  logic               hs;
  logic [WIDTH-1:0]   win_a, inv_a_q, inv_a_d;
  tag_t               tag_in, tag_last;
  // tag_q[0] sits alongside inv_a; tag_q[LATENCY] lines up with inv_f
  tag_t               tag_q [LATENCY+1];
  logic [N_REQ-1:0]   rsp_valid_q, rsp_valid_d;
  logic [WIDTH-1:0]   rsp_f_q, rsp_f_d;
  logic               rsp_dz_q, rsp_dz_d;
  logic [OUTST_W-1:0] outst_q [N_REQ];
  logic [OUTST_W-1:0] outst_d [N_REQ];

  rr_arbiter #(.N(N_REQ)) u_rr (
    .req       (eligible),
    .ptr       (ptr_q),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  assign req_ready = grant & {N_REQ{reset}};
  assign hs        = |req_ready;
  assign tag_last  = tag_q[LATENCY];

  always_comb begin
    eligible = '0;
    win_a    = '0;
    for (int i = 0; i < N_REQ; i++) begin
      eligible[i] = req_valid[i] && (outst_q[i] < MAX_O);
      if (grant[i]) win_a = req_a[i*WIDTH +: WIDTH];
    end
  end

  always_comb begin
    ptr_d   = ptr_q;
    inv_a_d = inv_a_q;
    tag_in  = '0;
    if (hs) begin
      ptr_d        = (grant_idx == IDX_W'(N_REQ - 1)) ? '0 : grant_idx + 1'b1;
      // never hand zero to the unit; the dz tag carries the saturation instead
      inv_a_d      = (win_a == '0) ? WIDTH'(1) : win_a;
      tag_in.valid = 1'b1;
      tag_in.id    = ID_W'(grant_idx);
      tag_in.dz    = (win_a == '0);
    end

    rsp_valid_d = '0;
    rsp_f_d     = rsp_f_q;
    rsp_dz_d    = rsp_dz_q;
    for (int i = 0; i < N_REQ; i++) begin
      if (tag_last.valid && tag_last.id == ID_W'(i)) rsp_valid_d[i] = 1'b1;
    end
    if (tag_last.valid) begin
      rsp_f_d  = tag_last.dz ? '1 : inv_f;
      rsp_dz_d = tag_last.dz;
    end

    for (int i = 0; i < N_REQ; i++) begin
      outst_d[i] = outst_q[i];
      if (req_ready[i] && !rsp_valid_d[i]) outst_d[i] = outst_q[i] + 1'b1;
      else if (!req_ready[i] && rsp_valid_d[i]) outst_d[i] = outst_q[i] - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr_q       <= '0;
      inv_a_q     <= '0;
      rsp_valid_q <= '0;
      rsp_f_q     <= '0;
      rsp_dz_q    <= 1'b0;
      for (int k = 0; k <= LATENCY; k++) tag_q[k] <= '0;
      for (int i = 0; i < N_REQ; i++) outst_q[i] <= '0;
    end else begin
      ptr_q       <= ptr_d;
      inv_a_q     <= inv_a_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_f_q     <= rsp_f_d;
      rsp_dz_q    <= rsp_dz_d;
      tag_q[0]    <= tag_in;
      for (int k = 1; k <= LATENCY; k++) tag_q[k] <= tag_q[k-1];
      for (int i = 0; i < N_REQ; i++) outst_q[i] <= outst_d[i];
    end
  end

  assign inv_a     = inv_a_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_f     = rsp_f_q;
  assign rsp_dz    = rsp_dz_q;

  for (genvar i = 0; i < N_REQ; i++) begin : g_outst
    assign outst[i*OUTST_W +: OUTST_W] = outst_q[i];
  end

endmodule

// File: tb/tb_uinv_arb.sv
// Bench for uinv_arb: table vectors, directed corner sequences and random
// traffic against a due-time scoreboard with a 2^32/a model of the unit.
module tb_uinv_arb;

  localparam int N    = 4;
  localparam int W    = 32;
  localparam int LAT  = 4;
  localparam int MAXO = 2;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic [N-1:0]     req_valid = '0;
  logic [N*W-1:0]   req_a = '0;
  logic [N-1:0]     req_ready;
  logic [W-1:0]     inv_a;
  logic [W-1:0]     inv_f;
  logic [N-1:0]     rsp_valid;
  logic [W-1:0]     rsp_f;
  logic             rsp_dz;
  logic [N*4-1:0]   outst;

  uinv_arb #(.N_REQ(N), .WIDTH(W), .SCALE(16), .LATENCY(LAT), .MAX_OUTST(MAXO)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .inv_a     (inv_a),
    .inv_f     (inv_f),
    .rsp_valid (rsp_valid),
    .rsp_f     (rsp_f),
    .rsp_dz    (rsp_dz),
    .outst     (outst)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] unit_f(input logic [W-1:0] x);
    logic [63:0] r;
    if (x == '0) return '0;
    r = 64'h1_0000_0000 / {32'd0, x};
    return r[W-1:0];
  endfunction

  logic [W-1:0] upipe [LAT];
  always @(posedge clk) begin
    upipe[0] <= unit_f(inv_a);
    for (int k = 1; k < LAT; k++) upipe[k] <= upipe[k-1];
  end
  assign inv_f = upipe[LAT-1];

  typedef struct {
    int           due;
    int           id;
    logic [W-1:0] a;
  } pend_t;

  typedef struct {
    int           id;
    logic [W-1:0] a;
    logic [W-1:0] f;
    logic         dz;
  } vec_t;

  int     n_vec = 0;
  int     n_err = 0;
  int     edge_n = 0;
  int     m_ptr = 0;
  int     m_outst [N];
  pend_t  q [$];
  vec_t   tbl [6];

  logic [N-1:0]   g, rv;
  logic [N*W-1:0] av, ra;

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (reset) begin
      for (int i = 0; i < N; i++) begin
        assert (outst[i*4 +: 4] <= 4'(MAXO)) else begin
          n_err++;
          $display("FAIL outst_range[%0d]: got %0d limit %0d", i, outst[i*4 +: 4], MAXO);
        end
      end
    end
  end

  // One clock: drive inputs after negedge, check grant, advance the model
  // at the edge, then check registered outputs on the next negedge.
  task automatic step(input logic [N-1:0] v, input logic [N*W-1:0] a, output logic [N-1:0] gr);
    logic [N-1:0] eg, er;
    logic [W-1:0] ef, ga;
    logic         edz;
    int           gi, idx;
    pend_t        p;
    req_valid = v;
    req_a     = a;
    #1;
    eg = '0;
    gi = -1;
    ga = '0;
    for (int k = 0; k < N; k++) begin
      idx = (m_ptr + k) % N;
      if (gi < 0 && v[idx] && m_outst[idx] < MAXO) begin
        gi      = idx;
        eg[idx] = 1'b1;
      end
    end
    chk("req_ready", W'(req_ready), W'(eg));
    @(posedge clk);
    edge_n++;
    er  = '0;
    ef  = '0;
    edz = 1'b0;
    if (q.size() > 0 && q[0].due == edge_n) begin
      p      = q.pop_front();
      er[p.id] = 1'b1;
      edz    = (p.a == '0);
      ef     = edz ? '1 : unit_f(p.a);
      m_outst[p.id]--;
    end
    if (gi >= 0) begin
      ga = a[gi*W +: W];
      q.push_back('{edge_n + LAT + 1, gi, ga});
      m_outst[gi]++;
      m_ptr = (gi + 1) % N;
    end
    @(negedge clk);
    chk("rsp_valid", W'(rsp_valid), W'(er));
    if (er != '0) begin
      chk("rsp_f", rsp_f, ef);
      chk("rsp_dz", W'(rsp_dz), W'(edz));
    end
    if (gi >= 0) chk("inv_a", inv_a, (ga == '0) ? W'(1) : ga);
    for (int i = 0; i < N; i++) chk("outst", W'(outst[i*4 +: 4]), W'(m_outst[i]));
    gr = eg;
  endtask

  task automatic idle(input int n);
    logic [N-1:0] gx;
    for (int k = 0; k < n; k++) step('0, '0, gx);
  endtask

  initial begin
    tbl[0] = '{0, 32'h0002_0000, 32'h0000_8000, 1'b0};
    tbl[1] = '{2, 32'h0000_0000, 32'hFFFF_FFFF, 1'b1};
    tbl[2] = '{1, 32'h0001_0000, 32'h0001_0000, 1'b0};
    tbl[3] = '{3, 32'h0000_8000, 32'h0002_0000, 1'b0};
    tbl[4] = '{3, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0};
    tbl[5] = '{1, 32'h0000_0003, 32'h5555_5555, 1'b0};
    for (int i = 0; i < N; i++) m_outst[i] = 0;

    req_valid = '1;
    #3;
    chk("rst_req_ready", W'(req_ready), '0);
    chk("rst_rsp_valid", W'(rsp_valid), '0);
    chk("rst_rsp_f", rsp_f, '0);
    chk("rst_inv_a", inv_a, '0);
    chk("rst_outst", W'(outst), '0);
    req_valid = '0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;

    // all four requesting: strict rotation from pointer 0
    for (int k = 0; k < 12; k++) begin
      for (int i = 0; i < N; i++) av[i*W +: W] = $urandom;
      step('1, av, g);
      chk("rr_order", W'(g), W'(N'(1) << (k % N)));
    end
    idle(LAT + 3);

    for (int t = 0; t < 6; t++) begin
      av = '0;
      av[tbl[t].id*W +: W] = tbl[t].a;
      step(N'(1) << tbl[t].id, av, g);
      idle(LAT + 1);
      chk("tbl_valid", W'(rsp_valid), W'(N'(1) << tbl[t].id));
      chk("tbl_f", rsp_f, tbl[t].f);
      chk("tbl_dz", W'(rsp_dz), W'(tbl[t].dz));
    end
    idle(2);

    // requester 1 alone: fills to MAX_OUTST, then re-accepted after first response
    av = '0;
    av[W +: W] = 32'h0004_0000;
    for (int k = 0; k < 7; k++) begin
      step(4'b0010, av, g);
      if (k == 2) begin
        chk("r1_blocked", W'(g), '0);
        chk("r1_outst", W'(outst[7:4]), 32'd2);
      end
      if (k == 6) chk("r1_reaccept", W'(g), 32'd2);
    end
    idle(LAT + 3);

    // handshake and response on requester 0 in the same cycle
    av = '0;
    av[0 +: W] = 32'h0000_0100;
    step(4'b0001, av, g);
    idle(LAT);
    step(4'b0001, av, g);
    chk("sim_rsp", W'(rsp_valid), 32'd1);
    chk("sim_outst", W'(outst[3:0]), 32'd1);
    idle(LAT + 3);

    // reset with three operations in flight
    for (int i = 0; i < N; i++) av[i*W +: W] = 32'h0010_0000 + i;
    step(4'b0001, av, g);
    step(4'b0010, av, g);
    step(4'b0100, av, g);
    req_valid = '1;
    #2;
    reset = 1'b0;
    #1;
    chk("mid_rst_req_ready", W'(req_ready), '0);
    chk("mid_rst_rsp_valid", W'(rsp_valid), '0);
    chk("mid_rst_rsp_f", rsp_f, '0);
    chk("mid_rst_rsp_dz", W'(rsp_dz), '0);
    chk("mid_rst_inv_a", inv_a, '0);
    chk("mid_rst_outst", W'(outst), '0);
    q.delete();
    for (int i = 0; i < N; i++) m_outst[i] = 0;
    m_ptr = 0;
    @(negedge clk);
    req_valid = '0;
    @(negedge clk);
    reset = 1'b1;
    idle(LAT + 3);
    step('1, av, g);
    chk("post_rst_ptr", W'(g), 32'd1);
    idle(LAT + 3);

    // random traffic, operands held until accepted
    rv = '0;
    ra = '0;
    for (int k = 0; k < 300; k++) begin
      for (int i = 0; i < N; i++) begin
        if (!rv[i] && $urandom_range(0, 2) == 0) begin
          rv[i] = 1'b1;
          ra[i*W +: W] = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom);
        end
      end
      step(rv, ra, g);
      rv = rv & ~g;
    end
    idle(LAT + 3);
    chk("drain_empty", W'(q.size()), '0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
